// File: rtl/mul_ternary_pkg.sv
// Shared constants, types and helpers for the ternary-multiplier host sequencer.
package mul_ternary_pkg;

    localparam int PARAM_N       = 512;
    localparam int COEF_PER_BEAT = 5;
    localparam int READ_STEP     = 4;
    localparam int CALC_GUARD    = 2;

    localparam logic [1:0] TER_ZERO    = 2'd0;
    localparam logic [1:0] TER_POS     = 2'd1;
    localparam logic [1:0] TER_ILLEGAL = 2'd2;
    localparam logic [1:0] TER_NEG     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_READ = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0] ter;
        logic [7:0] gen;
    } slot_t;

    // slot[0] occupies the lowest bits, matching the beat word layout
    typedef struct packed {
        logic [11:0]                   addr;
        slot_t [COEF_PER_BEAT-1:0]     slot;
    } beat_t;

    function automatic int beat_count(input int n);
        return (n + COEF_PER_BEAT - 1) / COEF_PER_BEAT;
    endfunction

    function automatic logic [1:0] ter_clean(input logic [1:0] ter);
        case (ter)
            TER_POS: return TER_POS;
            TER_NEG: return TER_NEG;
            default: return TER_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mul_ternary_packer.sv
// Accumulates (gen, ter) pairs into five-slot write beats; flushes a short final beat.
module mul_ternary_packer
    import mul_ternary_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic [7:0] gen,
    input  logic [1:0] ter,
    output beat_t      beat,
    output logic       beat_fire,
    output logic       last_fire
);

    localparam int         NUM_BEATS = beat_count(PARAM_N);
    localparam logic [2:0] LAST_SLOT = 3'((PARAM_N - 1) % COEF_PER_BEAT);
    localparam logic [2:0] FULL_SLOT = 3'(COEF_PER_BEAT - 1);

    logic [2:0]                count_r;
    logic [11:0]               base_r;
    logic [11:0]               beat_idx_r;
    slot_t [COEF_PER_BEAT-2:0] slot_r;
    slot_t                     new_s;

    // Build the outgoing beat: stored slots plus the pair arriving this cycle
    always_comb begin
        new_s.ter = ter_clean(ter);
        new_s.gen = gen;
        last_fire = push && (beat_idx_r == 12'(NUM_BEATS - 1)) && (count_r == LAST_SLOT);
        beat_fire = push && ((count_r == FULL_SLOT) || last_fire);
        beat.addr = base_r;
        beat.slot = {10'd0, slot_r};
        beat.slot[count_r] = new_s;
    end

    // Slot storage, fill count and beat base index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r    <= 3'd0;
            base_r     <= 12'd0;
            beat_idx_r <= 12'd0;
            slot_r     <= {(COEF_PER_BEAT-1){10'd0}};
        end else if (clear) begin
            count_r    <= 3'd0;
            base_r     <= 12'd0;
            beat_idx_r <= 12'd0;
            slot_r     <= {(COEF_PER_BEAT-1){10'd0}};
        end else if (push) begin
            if (beat_fire) begin
                count_r    <= 3'd0;
                base_r     <= base_r + 12'(COEF_PER_BEAT);
                beat_idx_r <= beat_idx_r + 12'd1;
                // cleared slots make the short final beat zero-padded
                slot_r     <= {(COEF_PER_BEAT-1){10'd0}};
            end else begin
                slot_r[count_r[1:0]] <= new_s;
                count_r              <= count_r + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mul_ternary_seq.sv
// Host sequencer for the ternary-multiplier accelerator: load beats, run, read back results.
module mul_ternary_seq
    import mul_ternary_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [7:0]  coef_gen,
    input  logic [1:0]  coef_ter,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        acc_enable_write,
    output logic        acc_enable_calc,
    output logic        acc_enable_read,
    output logic [31:0] acc_in_1,
    output logic [31:0] acc_in_2,
    input  logic [31:0] acc_out_1,
    input  logic        acc_ready
);

    localparam logic [11:0] LAST_WORD = 12'(PARAM_N / READ_STEP - 1);
    localparam logic [31:0] LAST_ADDR = 32'(PARAM_N - READ_STEP);
    localparam logic [1:0]  GUARD     = 2'(CALC_GUARD);

    state_e      state_r, state_nx_s;
    beat_t       beat_s;
    logic        beat_fire_s, last_fire_s;
    logic        start_s, accept_s, go_calc_s, calc_done_s, drain_s, final_s, issue_s;
    logic [1:0]  occ_nx_s;

    logic        coef_ready_r, res_valid_r, busy_r, done_r, err_r;
    logic        wr_r, calc_r, rd_r, last_wr_r, issue_done_r, arr_r, skid_valid_r;
    logic [1:0]  guard_r;
    logic [11:0] words_r;
    logic [31:0] in_1_r, in_2_r, res_data_r, skid_data_r;

    mul_ternary_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_s),
        .push      (accept_s),
        .gen       (coef_gen),
        .ter       (coef_ter),
        .beat      (beat_s),
        .beat_fire (beat_fire_s),
        .last_fire (last_fire_s)
    );

    // Handshake strobes and the read-issue decision
    always_comb begin
        start_s     = (state_r == ST_IDLE) && start;
        accept_s    = coef_valid && coef_ready_r;
        go_calc_s   = (state_r == ST_LOAD) && wr_r && last_wr_r;
        calc_done_s = (state_r == ST_CALC) && (guard_r == GUARD) && acc_ready;
        drain_s     = res_valid_r && res_ready;
        final_s     = (state_r == ST_READ) && drain_s && (words_r == LAST_WORD);
        // an address goes out only if its data is sure to find room next cycle
        occ_nx_s    = {1'b0, res_valid_r} + {1'b0, skid_valid_r} + {1'b0, arr_r} - {1'b0, drain_s};
        issue_s     = (state_r == ST_READ) && !issue_done_r && (occ_nx_s <= 2'd1);
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: state_nx_s = start_s     ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_nx_s = go_calc_s   ? ST_CALC : ST_LOAD;
            ST_CALC: state_nx_s = calc_done_s ? ST_READ : ST_CALC;
            ST_READ: state_nx_s = final_s     ? ST_IDLE : ST_READ;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Status flags, accelerator strobes, buses and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            wr_r         <= 1'b0;
            calc_r       <= 1'b0;
            rd_r         <= 1'b0;
            last_wr_r    <= 1'b0;
            issue_done_r <= 1'b0;
            arr_r        <= 1'b0;
            guard_r      <= 2'd0;
            words_r      <= 12'd0;
            in_1_r       <= 32'd0;
            in_2_r       <= 32'd0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= final_s;
            wr_r   <= beat_fire_s;
            arr_r  <= issue_s;

            if (start_s)                        coef_ready_r <= 1'b1;
            else if (accept_s && last_fire_s)   coef_ready_r <= 1'b0;

            if (start_s)                                err_r <= 1'b0;
            else if (accept_s && coef_ter == TER_ILLEGAL) err_r <= 1'b1;

            if (start_s)          last_wr_r <= 1'b0;
            else if (last_fire_s) last_wr_r <= 1'b1;

            if (beat_fire_s) begin
                in_1_r <= {2'b00, beat_s.slot[2], beat_s.slot[1], beat_s.slot[0]};
                in_2_r <= {beat_s.addr, beat_s.slot[4], beat_s.slot[3]};
            end else if (calc_done_s) begin
                in_1_r <= 32'd0;
            end else if (issue_s) begin
                in_1_r <= in_1_r + 32'(READ_STEP);
            end

            if (go_calc_s)        calc_r <= 1'b1;
            else if (calc_done_s) calc_r <= 1'b0;

            // a ready left over from the previous run is masked for GUARD cycles
            if (go_calc_s)                                  guard_r <= 2'd0;
            else if (state_r == ST_CALC && guard_r != GUARD) guard_r <= guard_r + 2'd1;

            if (calc_done_s)  rd_r <= 1'b1;
            else if (final_s) rd_r <= 1'b0;

            if (calc_done_s)                          issue_done_r <= 1'b0;
            else if (issue_s && in_1_r == LAST_ADDR)  issue_done_r <= 1'b1;

            if (calc_done_s)                          words_r <= 12'd0;
            else if (state_r == ST_READ && drain_s)   words_r <= words_r + 12'd1;
        end
    end

    // Output register with one skid entry so in-flight read data is never lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_r  <= 1'b0;
            res_data_r   <= 32'd0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= 32'd0;
        end else if (final_s) begin
            res_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!res_valid_r || drain_s) begin
            if (skid_valid_r) begin
                res_data_r   <= skid_data_r;
                res_valid_r  <= 1'b1;
                skid_valid_r <= arr_r;
                if (arr_r) skid_data_r <= acc_out_1;
            end else if (arr_r) begin
                res_data_r  <= acc_out_1;
                res_valid_r <= 1'b1;
            end else begin
                res_valid_r <= 1'b0;
            end
        end else if (arr_r) begin
            skid_data_r  <= acc_out_1;
            skid_valid_r <= 1'b1;
        end
    end

    assign coef_ready       = coef_ready_r;
    assign res_valid        = res_valid_r;
    assign res_data         = res_data_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err              = err_r;
    assign acc_enable_write = wr_r;
    assign acc_enable_calc  = calc_r;
    assign acc_enable_read  = rd_r;
    assign acc_in_1         = in_1_r;
    assign acc_in_2         = in_2_r;

endmodule

// File: tb/tb_mul_ternary_seq.sv
// Randomized bench for mul_ternary_seq with an accelerator responder and a result scoreboard.
module tb_mul_ternary_seq;

    localparam int N  = 512;
    localparam int NB = 103;
    localparam int NW = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, coef_valid = 1'b0, res_ready = 1'b0, acc_ready = 1'b0;
    logic [7:0]  coef_gen = 8'd0;
    logic [1:0]  coef_ter = 2'd0;
    logic [31:0] acc_out_1 = 32'd0;
    logic        coef_ready, res_valid, busy, done, err;
    logic        acc_enable_write, acc_enable_calc, acc_enable_read;
    logic [31:0] res_data, acc_in_1, acc_in_2;

    mul_ternary_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_gen(coef_gen), .coef_ter(coef_ter),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done), .err(err),
        .acc_enable_write(acc_enable_write), .acc_enable_calc(acc_enable_calc),
        .acc_enable_read(acc_enable_read), .acc_in_1(acc_in_1), .acc_in_2(acc_in_2),
        .acc_out_1(acc_out_1), .acc_ready(acc_ready)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [7:0]  gens [N];
    logic [1:0]  ters [N];
    logic [31:0] key;
    logic [31:0] prev_addr, held_data;
    logic        prev_rd, held_valid, last_hs;
    int wr_cnt, calc_len, res_cnt, done_cnt, cycles, pair_idx;
    int bp_mode, stale, coef_rate, stall_left;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accelerator read data: an arbitrary mix of the address and a per-run key
    function automatic logic [31:0] acc_word(input logic [31:0] addr);
        return (addr * 32'h9E3779B1) ^ key;
    endfunction

    function automatic logic [31:0] slot_val(input int idx);
        logic [1:0] t;
        if (idx >= N) return 32'd0;
        t = (ters[idx] == 2'd2) ? 2'd0 : ters[idx];
        return 32'(gens[idx]) + 32'(t) * 32'd256;
    endfunction

    function automatic logic [31:0] exp_lo(input int b);
        return slot_val(5*b) + slot_val(5*b+1) * 32'd1024 + slot_val(5*b+2) * 32'd1048576;
    endfunction

    function automatic logic [31:0] exp_hi(input int b);
        return 32'(5*b) * 32'd1048576 + slot_val(5*b+3) + slot_val(5*b+4) * 32'd1024;
    endfunction

    // One clock of bench activity, sampled and driven at the falling edge
    task automatic cycle();
        @(negedge clk);
        cycles++;
        if (acc_enable_write) begin
            check("beat_lo", acc_in_1, exp_lo(wr_cnt));
            check("beat_hi", acc_in_2, exp_hi(wr_cnt));
            wr_cnt++;
        end
        if (acc_enable_calc) calc_len++;
        if (held_valid) begin
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, held_data);
        end
        if (last_hs) begin
            check("done_after_last", done, 1'b1);
            check("busy_at_done", busy, 1'b0);
            last_hs = 1'b0;
        end
        if (done) done_cnt++;
        acc_out_1 = prev_rd ? acc_word(prev_addr) : 32'd0;
        prev_addr = acc_in_1;
        prev_rd   = acc_enable_read;
        if (stale != 0) acc_ready = busy && !acc_enable_read;
        else            acc_ready = acc_enable_calc && (calc_len >= 4);
        case (bp_mode)
            0: res_ready = 1'b1;
            1: begin
                if (res_cnt >= 20 && stall_left > 0) begin
                    res_ready = 1'b0;
                    stall_left--;
                end else begin
                    res_ready = (cycles % 2 == 0);
                end
            end
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
        if (res_valid && res_ready) begin
            check("res_data", res_data, acc_word(32'(res_cnt * 4)));
            res_cnt++;
            if (res_cnt == NW) last_hs = 1'b1;
        end
        held_valid = res_valid && !res_ready;
        held_data  = res_data;
        if (pair_idx < N && $urandom_range(0, 99) < coef_rate) begin
            coef_valid = 1'b1;
            coef_gen   = gens[pair_idx];
            coef_ter   = ters[pair_idx];
            if (coef_ready) pair_idx++;
        end else begin
            coef_valid = 1'b0;
            coef_gen   = 8'($urandom);
            coef_ter   = 2'd0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {coef_ready, res_valid, busy, done, err,
                              acc_enable_write, acc_enable_calc, acc_enable_read}, 8'h00);
        check({tag, "_in1"}, acc_in_1, 32'd0);
        check({tag, "_in2"}, acc_in_2, 32'd0);
        check({tag, "_res"}, res_data, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1 check_all_zero(tag);
        coef_valid = 1'b0;
        acc_ready  = 1'b0;
        start      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // bp: 0 ready high, 1 toggle plus 10-cycle stall, 2 random; intr: 1 mid-LOAD, 2 mid-READ
    task automatic run_op(input int bp, input int st, input int rate, input int bad_idx, input int intr);
        int r, guard;
        for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 2);
            gens[i] = 8'($urandom);
            ters[i] = (r == 2) ? 2'd3 : 2'(r);
        end
        if (bad_idx >= 0) begin
            ters[bad_idx] = 2'd2;
            gens[bad_idx] = 8'd0;
        end
        key = $urandom;
        wr_cnt = 0; calc_len = 0; res_cnt = 0; done_cnt = 0; pair_idx = 0; cycles = 0;
        last_hs = 1'b0; held_valid = 1'b0; prev_rd = 1'b0; prev_addr = 32'd0;
        bp_mode = bp; stale = st; coef_rate = rate; stall_left = 10;

        coef_rate = 100;
        cycle();
        check("idle_coef_ready", coef_ready, 1'b0);
        cycle();
        check("idle_no_accept", pair_idx, 0);
        coef_rate = rate;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("coef_ready_load", coef_ready, 1'b1);
        check("err_cleared", err, 1'b0);

        guard = 0;
        while (done_cnt == 0 && guard < 5000) begin
            start = busy && (guard % 7 == 3);
            if (intr == 1 && pair_idx >= 40) begin
                do_reset("rst_load");
                return;
            end
            if (intr == 2 && res_cnt >= 50) begin
                do_reset("rst_read");
                return;
            end
            cycle();
            guard++;
        end
        start = 1'b0;
        check("op_timeout", done_cnt > 0, 1'b1);
        check("write_beats", wr_cnt, NB);
        check("result_words", res_cnt, NW);
        check("calc_len", calc_len, (st != 0) ? 3 : 4);
        check("err_flag", err, bad_idx >= 0);
        cycle();
        cycle();
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        run_op(0, 0, 100, -1, 0);
        run_op(0, 1, 100, -1, 0);
        run_op(1, 0, 80, -1, 0);
        run_op(2, 0, 70, 7, 0);
        run_op(0, 0, 100, -1, 1);
        run_op(2, 0, 100, -1, 2);
        run_op(0, 0, 100, -1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
